// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one multi-cycle ALU (add/sub/mul/div with a start/done handshake)
//   among N_REQ requesters. Requesters offer operand/opcode transactions on a
//   valid/ready interface. The arbiter grants them round-robin, latches the
//   operands, runs the ALU handshake and returns the result tagged with the
//   requester ID. Only one transaction is in flight at a time.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid[N_REQ]  : per-requester transaction valid
//   req_ready[N_REQ]  : one-hot accept (combinational, only in IDLE)
//   req_a/req_b       : packed operands, requester i uses [i*W +: W]
//   req_op            : packed opcodes, requester i uses [i*3 +: 3]
//                       000 add, 001 sub, 010 mul, 011 div, 1xx illegal
//   rsp_valid         : one-cycle result strobe
//   rsp_id            : requester index of the result
//   rsp_low/rsp_high  : ALU result halves (zero for an illegal opcode)
//   rsp_err           : illegal opcode flag
//   busy              : high whenever the arbiter is not IDLE
//   alu_a/alu_b       : registered operands to the ALU
//   alu_opcode        : registered opcode to the ALU
//   alu_start         : one-cycle ALU start pulse
//   alu_result_low/high, alu_done : ALU result and completion pulse
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_op,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [W:0]         rsp_low,
  output logic [W:0]         rsp_high,
  output logic               rsp_err,
  output logic               busy,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [2:0]         alu_opcode,
  output logic               alu_start,
  input  logic [W:0]         alu_result_low,
  input  logic [W:0]         alu_result_high,
  input  logic               alu_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERR   = 3'd3,
    ST_RESP  = 3'd4,
    ST_COOL  = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [IDW-1:0]     ptr_r;

  logic               grant_found_s;
  logic               grant_hit_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [IDW-1:0]     cand_s;
  logic [2:0]         grant_op_s;
  logic [N_REQ-1:0]   req_ready_s;

  logic [W-1:0]       alu_a_r;
  logic [W-1:0]       alu_b_r;
  logic [2:0]         alu_opcode_r;
  logic               alu_start_r;
  logic               rsp_valid_r;
  logic [IDW-1:0]     rsp_id_r;
  logic [W:0]         rsp_low_r;
  logic [W:0]         rsp_high_r;
  logic               rsp_err_r;
  logic               busy_r;

  // Round-robin search: first valid requester strictly after ptr_r, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_hit_s   = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    cand_s        = {IDW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s        = IDW'((int'(ptr_r) + k) % N_REQ);
      grant_hit_s   = ~grant_found_s & req_valid[cand_s];
      grant_idx_s   = grant_hit_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | grant_hit_s;
    end
  end

  assign grant_op_s = req_op[int'(grant_idx_s)*3 +: 3];

  // Next-state decode and the combinational accept strobe.
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = {N_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s[grant_idx_s] = 1'b1;
          if (grant_op_s[2]) begin
            state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ERR:  state_next_s = ST_RESP;
      ST_RESP: state_next_s = ST_COOL;
      // One spare cycle lets the ALU leave its own FINISH state first.
      ST_COOL: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign req_ready = req_ready_s;

  // State register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= IDW'(N_REQ - 1);
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_IDLE && grant_found_s) begin
        ptr_r <= grant_idx_s;
      end
    end
  end

  // Operand latch toward the ALU and result capture toward the requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a_r      <= {W{1'b0}};
      alu_b_r      <= {W{1'b0}};
      alu_opcode_r <= 3'b000;
      rsp_id_r     <= {IDW{1'b0}};
      rsp_low_r    <= {(W+1){1'b0}};
      rsp_high_r   <= {(W+1){1'b0}};
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            alu_a_r      <= req_a[int'(grant_idx_s)*W +: W];
            alu_b_r      <= req_b[int'(grant_idx_s)*W +: W];
            alu_opcode_r <= grant_op_s;
            rsp_id_r     <= grant_idx_s;
            if (!grant_op_s[2]) begin
              rsp_err_r <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          // A done pulse outside WAIT never reaches this capture.
          if (alu_done) begin
            rsp_low_r  <= alu_result_low;
            rsp_high_r <= alu_result_high;
          end
        end
        ST_ERR: begin
          rsp_low_r  <= {(W+1){1'b0}};
          rsp_high_r <= {(W+1){1'b0}};
          rsp_err_r  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered strobes, decoded from the state about to be entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_start_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      alu_start_r <= (state_next_s == ST_ISSUE);
      rsp_valid_r <= (state_next_s == ST_RESP);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_opcode_r;
  assign alu_start  = alu_start_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_low    = rsp_low_r;
  assign rsp_high   = rsp_high_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;

endmodule
